// File: rtl/sub_bytes_ced_pkg.sv
// Shared types, S-box table and parity-prediction helpers for the CED SubBytes stage.
package aes_ced_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   // AES forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
      return SBOX_TBL[11'd2047 - {b, 3'b000} -: 8];
   endfunction

   // Built at elaboration so the prediction table cannot drift from the S-box contents.
   function automatic logic [255:0] gen_par_pred();
      logic [255:0] t;
      t = '0;
      for (int unsigned i = 0; i < 256; i++) begin
         t[i] = ^sbox_lookup(8'(i));
      end
      return t;
   endfunction

   localparam logic [255:0] SBOX_PAR_PRED = gen_par_pred();

   function automatic logic sbox_par_pred(input logic [7:0] b);
      return SBOX_PAR_PRED[b];
   endfunction

   // MSB position of byte idx in a 128-bit state (byte 0 is the top byte).
   function automatic logic [6:0] byte_msb(input logic [3:0] idx);
      return 7'd127 - {idx, 3'b000};
   endfunction

endpackage

// File: rtl/sub_bytes_ced_if.sv
// Handshake and data bundle for the CED SubBytes stage.
interface sub_bytes_ced_if;

   logic         InValid_SI;
   logic         InReady_SO;
   logic [127:0] State_DI;
   logic [7:0]   FaultMask_DI;
   logic         OutValid_SO;
   logic         OutReady_SI;
   logic [127:0] State_DO;
   logic [15:0]  ErrByte_DO;
   logic         Err_SO;

   modport master (
      output InValid_SI,
      output State_DI,
      output FaultMask_DI,
      output OutReady_SI,
      input  InReady_SO,
      input  OutValid_SO,
      input  State_DO,
      input  ErrByte_DO,
      input  Err_SO
   );

   modport slave (
      input  InValid_SI,
      input  State_DI,
      input  FaultMask_DI,
      input  OutReady_SI,
      output InReady_SO,
      output OutValid_SO,
      output State_DO,
      output ErrByte_DO,
      output Err_SO
   );

endinterface

// File: rtl/sbox.sv
// Combinational AES forward S-box with output parity.
module sbox
   import aes_ced_pkg::*;
(
   input  logic [7:0] In_DI,
   output logic [7:0] Out_DO,
   output logic       Parity_SO
);

   // Table lookup plus even-parity of the substituted byte
   always_comb begin
      Out_DO    = sbox_lookup(In_DI);
      Parity_SO = ^Out_DO;
   end

endmodule

// File: rtl/sub_bytes_ced.sv
// Iterative SubBytes: LANES bytes per cycle, with per-byte parity-based error detection.
module sub_bytes_ced
   import aes_ced_pkg::*;
#(
   parameter int unsigned LANES    = 4,
   parameter bit          CHECK_EN = 1'b1
) (
   input  logic           Clk_CI,
   input  logic           Rst_RBI,
   sub_bytes_ced_if.slave bus
);

   localparam int unsigned N  = 16 / LANES;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic            last;
   logic [127:0]    in_q;
   logic [127:0]    out_q;
   logic [15:0]     err_q;
   logic [3:0]      base;

   logic [3:0]      lane_idx [LANES];
   logic [7:0]      lane_in  [LANES];
   logic [7:0]      lane_raw [LANES];
   logic [7:0]      lane_res [LANES];
   logic            lane_err [LANES];
   logic [LANES-1:0] sbox_par_unused;

   assign last = (cnt_q == CW'(N - 1));

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      sbox u_sbox (
         .In_DI     (lane_in[g]),
         .Out_DO    (lane_raw[g]),
         .Parity_SO (sbox_par_unused[g])
      );
   end

   // Select this cycle's group of input bytes
   always_comb begin
      base = 4'(cnt_q * LANES);
      for (int unsigned k = 0; k < LANES; k++) begin
         lane_idx[k] = base + 4'(k);
         lane_in[k]  = in_q[byte_msb(lane_idx[k]) -: 8];
      end
   end

   // Apply lane-0 fault injection, then compare actual against predicted parity
   always_comb begin
      for (int unsigned k = 0; k < LANES; k++) begin
         lane_res[k] = lane_raw[k] ^ ((k == 0) ? bus.FaultMask_DI : 8'h00);
         lane_err[k] = CHECK_EN && (sbox_par_pred(lane_in[k]) != ^lane_res[k]);
      end
   end

   // FSM state register
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      state_d         = state_q;
      bus.InReady_SO  = 1'b0;
      bus.OutValid_SO = 1'b0;
      case (state_q)
         IDLE: begin
            bus.InReady_SO = 1'b1;
            if (bus.InValid_SI) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bus.OutValid_SO = 1'b1;
            if (bus.OutReady_SI) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture input, step the byte counter, scatter lane results and error bits
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         in_q  <= '0;
         out_q <= '0;
         err_q <= '0;
         cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.InValid_SI) begin
                  in_q  <= bus.State_DI;
                  err_q <= '0;
                  cnt_q <= '0;
               end
            end
            RUN: begin
               for (int unsigned k = 0; k < LANES; k++) begin
                  out_q[byte_msb(lane_idx[k]) -: 8] <= lane_res[k];
                  err_q[lane_idx[k]]                <= lane_err[k];
               end
               cnt_q <= last ? '0 : cnt_q + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // Result registers drive the output bus directly
   always_comb begin
      bus.State_DO   = out_q;
      bus.ErrByte_DO = err_q;
      bus.Err_SO     = |err_q;
   end

endmodule

// File: tb/tb_sub_bytes_ced.sv
// Self-checking bench: three instances (LANES 1, 4, 16) driven in lockstep and compared
// against a GF(2^8)-arithmetic reference of SubBytes.
`timescale 1ns/1ps
module tb_sub_bytes_ced;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] in_state = '0;
   logic [7:0]   fmask = '0;

   int unsigned  n_checks = 0;
   int unsigned  n_pass = 0;
   logic [7:0]   ref_sbox [256];

   always #5 clk = ~clk;

   sub_bytes_ced_if bus_l1 ();
   sub_bytes_ced_if bus_l4 ();
   sub_bytes_ced_if bus_l16 ();

   assign bus_l1.InValid_SI    = in_valid;
   assign bus_l1.State_DI      = in_state;
   assign bus_l1.FaultMask_DI  = fmask;
   assign bus_l1.OutReady_SI   = out_ready;
   assign bus_l4.InValid_SI    = in_valid;
   assign bus_l4.State_DI      = in_state;
   assign bus_l4.FaultMask_DI  = fmask;
   assign bus_l4.OutReady_SI   = out_ready;
   assign bus_l16.InValid_SI   = in_valid;
   assign bus_l16.State_DI     = in_state;
   assign bus_l16.FaultMask_DI = fmask;
   assign bus_l16.OutReady_SI  = out_ready;

   sub_bytes_ced #(.LANES(1), .CHECK_EN(1'b1)) u_dut_l1 (
      .Clk_CI(clk), .Rst_RBI(rst_n), .bus(bus_l1.slave));
   sub_bytes_ced #(.LANES(4), .CHECK_EN(1'b1)) u_dut_l4 (
      .Clk_CI(clk), .Rst_RBI(rst_n), .bus(bus_l4.slave));
   sub_bytes_ced #(.LANES(16), .CHECK_EN(1'b1)) u_dut_l16 (
      .Clk_CI(clk), .Rst_RBI(rst_n), .bus(bus_l16.slave));

   logic         ov [3];
   logic         ir [3];
   logic [127:0] so [3];
   logic [15:0]  eb [3];
   logic         ef [3];

   assign ov[0] = bus_l1.OutValid_SO;  assign ov[1] = bus_l4.OutValid_SO;  assign ov[2] = bus_l16.OutValid_SO;
   assign ir[0] = bus_l1.InReady_SO;   assign ir[1] = bus_l4.InReady_SO;   assign ir[2] = bus_l16.InReady_SO;
   assign so[0] = bus_l1.State_DO;     assign so[1] = bus_l4.State_DO;     assign so[2] = bus_l16.State_DO;
   assign eb[0] = bus_l1.ErrByte_DO;   assign eb[1] = bus_l4.ErrByte_DO;   assign eb[2] = bus_l16.ErrByte_DO;
   assign ef[0] = bus_l1.Err_SO;       assign ef[1] = bus_l4.Err_SO;       assign ef[2] = bus_l16.Err_SO;

   function automatic int unsigned lanes_of(input int d);
      return (d == 0) ? 1 : (d == 1) ? 4 : 16;
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r, sq, e;
      r = 8'h01; sq = a; e = 8'd254;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = gf_mul(r, sq);
         sq = gf_mul(sq, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] x);
      return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] exp_state(input logic [127:0] st, input logic [7:0] m,
                                              input int unsigned lanes);
      logic [127:0] r;
      logic [7:0]   b;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         b = st[127 - 8*i -: 8];
         r[127 - 8*i -: 8] = ref_sbox[b] ^ (((i % lanes) == 0) ? m : 8'h00);
      end
      return r;
   endfunction

   function automatic logic [15:0] exp_err(input logic [7:0] m, input int unsigned lanes);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         r[i] = ((i % lanes) == 0) && (^m);
      end
      return r;
   endfunction

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [127:0] st, input logic [7:0] m);
      int unsigned waited;
      waited = 0;
      in_state = st;
      fmask    = m;
      in_valid = 1'b1;
      while (!(ir[0] && ir[1] && ir[2]) && waited < 40) begin
         @(posedge clk); #1;
         waited++;
      end
      check_eq("in_ready_before_accept", {ir[0], ir[1], ir[2]}, 3'b111);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_eq("in_ready_after_accept", {ir[0], ir[1], ir[2]}, 3'b000);
   endtask

   task automatic wait_out(input logic [127:0] st, input logic [7:0] m);
      int unsigned lat [3];
      bit          all_v;
      lat = '{0, 0, 0};
      all_v = 1'b0;
      for (int c = 1; c <= 40 && !all_v; c++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++) begin
            if (ov[d] && lat[d] == 0) lat[d] = c;
         end
         all_v = ov[0] && ov[1] && ov[2];
      end
      for (int d = 0; d < 3; d++) begin
         check_eq($sformatf("latency_l%0d", lanes_of(d)), lat[d], 16 / lanes_of(d));
         check_eq($sformatf("state_l%0d", lanes_of(d)), so[d], exp_state(st, m, lanes_of(d)));
         check_eq($sformatf("errbyte_l%0d", lanes_of(d)), eb[d], exp_err(m, lanes_of(d)));
         check_eq($sformatf("err_l%0d", lanes_of(d)), ef[d], |exp_err(m, lanes_of(d)));
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_eq("idle_after_release", {ir[0], ir[1], ir[2], ov[0], ov[1], ov[2]}, 6'b111000);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [127:0] st_a, st_b;
      logic [7:0]   m;

      for (int i = 0; i < 256; i++) ref_sbox[i] = affine(gf_inv(8'(i)));

      // reset values
      #12;
      for (int d = 0; d < 3; d++) begin
         check_eq($sformatf("rst_outs_l%0d", lanes_of(d)),
                  {ir[d], ov[d], ef[d], eb[d], so[d]}, {3'b100, 16'h0, 128'h0});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;

      // all-zero state
      send('0, 8'h00);
      wait_out('0, 8'h00);
      check_eq("zero_literal", so[1], {16{8'h63}});
      release_out();

      // FIPS-197 SubBytes vector
      st_a = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
      send(st_a, 8'h00);
      wait_out(st_a, 8'h00);
      check_eq("fips_literal", so[1], 128'hd42711aee0bf98f1b8b45de51e415230);
      release_out();

      // single-bit fault on lane 0
      send('0, 8'h01);
      wait_out('0, 8'h01);
      check_eq("fault01_state", so[1], 128'h62636363626363636263636362636363);
      check_eq("fault01_errbyte", eb[1], 16'h1111);
      check_eq("fault01_err", ef[1], 1'b1);
      release_out();

      // backpressure with a new input waiting
      st_a = {$urandom, $urandom, $urandom, $urandom};
      st_b = {$urandom, $urandom, $urandom, $urandom};
      send(st_a, 8'h00);
      wait_out(st_a, 8'h00);
      in_state = st_b;
      in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("bp_hold_l%0d", lanes_of(d)), {ov[d], ir[d], so[d]},
                     {2'b10, exp_state(st_a, 8'h00, lanes_of(d))});
         end
      end
      release_out();
      send(st_b, 8'h00);
      wait_out(st_b, 8'h00);
      release_out();

      // asynchronous reset mid-RUN (LANES=4 counter at 2)
      send({$urandom, $urandom, $urandom, $urandom}, 8'h00);
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         check_eq($sformatf("midrun_rst_l%0d", lanes_of(d)), {ov[d], ir[d], so[d]},
                  {2'b01, 128'h0});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      st_a = 128'h00112233445566778899aabbccddeeff;
      send(st_a, 8'h00);
      wait_out(st_a, 8'h00);
      release_out();

      // randomized states and masks
      for (int t = 0; t < 1000; t++) begin
         st_a = {$urandom, $urandom, $urandom, $urandom};
         case ($urandom_range(0, 4))
            0, 1:    m = 8'h00;
            2:       m = 8'h03;
            3:       m = 8'h80;
            default: m = 8'($urandom);
         endcase
         send(st_a, m);
         wait_out(st_a, m);
         release_out();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
